// File: rtl/mem_access.sv
// MEM stage: turns EXE/MEM loads and stores into a single-outstanding data
// memory request, stalls upstream while it waits, and retires to MEM/WB.
module mem_access #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        Valid_IN,
  input  logic        MemRead_IN,
  input  logic        MemWrite_IN,
  input  logic [1:0]  MemSize_IN,
  input  logic        MemSigned_IN,
  input  logic [31:0] ALUResult_IN,
  input  logic [31:0] StoreData_IN,
  input  logic [4:0]  WriteRegister_IN,
  input  logic        RegWrite_IN,
  output logic        DMemReq_OUT,
  output logic        DMemWrite_OUT,
  output logic [31:0] DMemAddr_OUT,
  output logic [31:0] DMemWData_OUT,
  output logic [3:0]  DMemByteEn_OUT,
  input  logic        DMemAck_IN,
  input  logic [31:0] DMemRData_IN,
  output logic        Stall_OUT,
  output logic        Valid_OUT,
  output logic [31:0] WriteData_OUT,
  output logic [4:0]  WriteRegister_OUT,
  output logic        RegWrite_OUT,
  output logic        Misaligned_OUT,
  output logic        Timeout_OUT
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, nextState;

  logic memOp, misaligned, isHalf, isWord, issue, stall;
  logic [1:0] off;
  logic [3:0] byteEn;
  logic [31:0] wData;

  assign memOp = Valid_IN & (MemRead_IN | MemWrite_IN);
  assign off = ALUResult_IN[1:0];
  assign isHalf = (MemSize_IN == 2'b01);
  assign isWord = MemSize_IN[1];
  assign misaligned = (isHalf & off[0]) | (isWord & (off != 2'b00));
  assign issue = memOp & ~misaligned;

  always_comb begin
    byteEn = 4'b1111;
    wData = StoreData_IN;
    unique case (1'b1)
      isWord: byteEn = 4'b1111;
      isHalf: begin
        byteEn = off[1] ? 4'b0011 : 4'b1100;
        wData = {2{StoreData_IN[15:0]}};
      end
      default: begin
        byteEn = 4'b1000 >> off;
        wData = {4{StoreData_IN[7:0]}};
      end
    endcase
  end

  // Everything needed at retirement is latched at issue, so DONE never
  // looks at the (already advancing) EXE/MEM register.
  logic [1:0]    sizeQ, offQ;
  logic          signedQ, storeQ, regWriteQ, timedOutQ;
  logic [4:0]    wregQ;
  logic [31:0]   aluQ, loadQ, loadVal;
  logic [CW-1:0] cnt;
  logic [7:0]    lb;
  logic [15:0]   lh;

  always_comb begin
    unique case (offQ)
      2'd0: lb = DMemRData_IN[31:24];
      2'd1: lb = DMemRData_IN[23:16];
      2'd2: lb = DMemRData_IN[15:8];
      default: lb = DMemRData_IN[7:0];
    endcase
    lh = offQ[1] ? DMemRData_IN[15:0] : DMemRData_IN[31:16];
    loadVal = DMemRData_IN;
    unique case (sizeQ)
      2'b00: loadVal = {{24{signedQ & lb[7]}}, lb};
      2'b01: loadVal = {{16{signedQ & lh[15]}}, lh};
      default: loadVal = DMemRData_IN;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else state <= nextState;
  end

  always_comb begin
    nextState = state;
    stall = 1'b0;
    unique case (state)
      IDLE: begin
        if (issue) begin
          nextState = ACCESS;
          stall = 1'b1;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (DMemAck_IN || cnt == LAST) nextState = DONE;
      end
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign Stall_OUT = stall & RESET;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      DMemReq_OUT <= 1'b0;
      DMemWrite_OUT <= 1'b0;
      DMemAddr_OUT <= '0;
      DMemWData_OUT <= '0;
      DMemByteEn_OUT <= '0;
      Valid_OUT <= 1'b0;
      WriteData_OUT <= '0;
      WriteRegister_OUT <= '0;
      RegWrite_OUT <= 1'b0;
      Misaligned_OUT <= 1'b0;
      Timeout_OUT <= 1'b0;
      sizeQ <= '0;
      offQ <= '0;
      signedQ <= 1'b0;
      storeQ <= 1'b0;
      regWriteQ <= 1'b0;
      timedOutQ <= 1'b0;
      wregQ <= '0;
      aluQ <= '0;
      loadQ <= '0;
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          Valid_OUT <= Valid_IN & (~memOp | misaligned);
          RegWrite_OUT <= Valid_IN & ~memOp & RegWrite_IN;
          Misaligned_OUT <= memOp & misaligned;
          Timeout_OUT <= 1'b0;
          WriteData_OUT <= ALUResult_IN;
          WriteRegister_OUT <= WriteRegister_IN;
          if (issue) begin
            DMemReq_OUT <= 1'b1;
            DMemWrite_OUT <= MemWrite_IN;
            DMemAddr_OUT <= {ALUResult_IN[31:2], 2'b00};
            DMemWData_OUT <= wData;
            DMemByteEn_OUT <= byteEn;
            sizeQ <= MemSize_IN;
            offQ <= off;
            signedQ <= MemSigned_IN;
            storeQ <= MemWrite_IN;
            regWriteQ <= RegWrite_IN;
            wregQ <= WriteRegister_IN;
            aluQ <= ALUResult_IN;
            cnt <= '0;
          end
        end
        ACCESS: begin
          Valid_OUT <= 1'b0;
          RegWrite_OUT <= 1'b0;
          Misaligned_OUT <= 1'b0;
          Timeout_OUT <= 1'b0;
          if (DMemAck_IN) begin
            loadQ <= loadVal;
            DMemReq_OUT <= 1'b0;
            timedOutQ <= 1'b0;
          end else if (cnt == LAST) begin
            DMemReq_OUT <= 1'b0;
            timedOutQ <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          Valid_OUT <= 1'b1;
          WriteRegister_OUT <= wregQ;
          Misaligned_OUT <= 1'b0;
          Timeout_OUT <= timedOutQ;
          RegWrite_OUT <= ~timedOutQ & ~storeQ & regWriteQ;
          WriteData_OUT <= (storeQ | timedOutQ) ? aluQ : loadQ;
        end
        default: ;
      endcase
    end
  end
endmodule
